// File: rtl/gf256_pkg.sv
// Shared types and helpers for the GF(2^8) multiply engine.
// Field arithmetic uses the low byte of the reduction polynomial; 0x11B is the AES field.
package gf256_pkg;

  localparam logic [7:0] AES_POLY_LO = 8'h1B;

  // Upper bound on lane count that lane_byte() can address.
  localparam int unsigned MaxLanes = 32;

  typedef logic [8*MaxLanes-1:0] lane_vec_t;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b, input logic [7:0] poly);
    return {b[6:0], 1'b0} ^ (b[7] ? poly : 8'h00);
  endfunction

  function automatic logic [7:0] lane_byte(input lane_vec_t vec, input int unsigned idx);
    return vec[8*idx +: 8];
  endfunction

endpackage

// File: rtl/gf256_mul_step.sv
// One lane of the shift-and-add multiplier: applies Steps iterations combinationally.
module gf256_mul_step
  import gf256_pkg::*;
#(
  parameter int unsigned Steps = 2,
  parameter logic [7:0]  Poly  = AES_POLY_LO
) (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic [7:0] p_i,
  output logic [7:0] a_o,
  output logic [7:0] b_o,
  output logic [7:0] p_o
);

  always_comb begin
    a_o = a_i;
    b_o = b_i;
    p_o = p_i;
    for (int unsigned s = 0; s < Steps; s++) begin
      if (b_o[0]) p_o = p_o ^ a_o;
      a_o = xtime(a_o, Poly);
      b_o = b_o >> 1;
    end
  end

endmodule

// File: rtl/gf256_mul_engine.sv
// Multi-lane GF(2^8) multiplier with valid/ready handshake; STEPS_PER_CYCLE trades area
// for latency (8/STEPS_PER_CYCLE busy cycles per transaction).
module gf256_mul_engine
  import gf256_pkg::*;
#(
  parameter int unsigned LANES           = 4,
  parameter int unsigned STEPS_PER_CYCLE = 2,
  parameter logic [7:0]  POLY            = AES_POLY_LO
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               In_Valid,
  output logic               In_Ready,
  input  logic [8*LANES-1:0] In_A,
  input  logic [8*LANES-1:0] In_B,
  output logic               Out_Valid,
  input  logic               Out_Ready,
  output logic [8*LANES-1:0] Out_Data,
  output logic               Busy
);

  localparam int unsigned Iter = 8 / STEPS_PER_CYCLE;
  localparam int unsigned CntW = (Iter + 1 > 2) ? $clog2(Iter + 1) : 1;

  if (!(STEPS_PER_CYCLE inside {1, 2, 4, 8}) || LANES == 0 || LANES > MaxLanes) begin : g_bad_cfg
    $error("gf256_mul_engine: STEPS_PER_CYCLE must be 1/2/4/8 and LANES in 1..MaxLanes");
  end

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [8*LANES-1:0]  a_q, a_d, b_q, b_d, p_q, p_d;
  logic [8*LANES-1:0]  a_step, b_step, p_step;
  logic                accept;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    gf256_mul_step #(
      .Steps (STEPS_PER_CYCLE),
      .Poly  (POLY)
    ) u_step (
      .a_i (lane_byte(lane_vec_t'(a_q), i)),
      .b_i (lane_byte(lane_vec_t'(b_q), i)),
      .p_i (lane_byte(lane_vec_t'(p_q), i)),
      .a_o (a_step[8*i +: 8]),
      .b_o (b_step[8*i +: 8]),
      .p_o (p_step[8*i +: 8])
    );
  end

  // Ready never looks at In_*, so there is no combinational In_* -> Out_* path.
  assign In_Ready  = (state_q == StIdle) | ((state_q == StDone) & Out_Ready);
  assign accept    = In_Valid & In_Ready;
  assign Out_Valid = (state_q == StDone);
  assign Out_Data  = Out_Valid ? p_q : '0;
  assign Busy      = (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    unique case (state_q)
      StIdle: ;
      StBusy: begin
        a_d   = a_step;
        b_d   = b_step;
        p_d   = p_step;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StDone;
      end
      StDone: begin
        if (Out_Ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // A request taken while DONE retires the old result and starts the new one in one edge.
    if (accept) begin
      a_d     = In_A;
      b_d     = In_B;
      p_d     = '0;
      cnt_d   = CntW'(Iter);
      state_d = StBusy;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
    end
  end

endmodule

// File: tb/tb_gf256_mul_engine.sv
// Scoreboard bench for gf256_mul_engine: driver pushes expected products, monitor pops and
// compares on each output handshake; a side set of instances covers the latency sweep.
module tb_gf256_mul_engine;

  localparam int unsigned Iter = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] in_a, in_b, out_data;

  gf256_mul_engine #(
    .LANES           (4),
    .STEPS_PER_CYCLE (2),
    .POLY            (8'h1B)
  ) u_dut (
    .CLK       (clk),
    .RST       (rst),
    .In_Valid  (in_valid),
    .In_Ready  (in_ready),
    .In_A      (in_a),
    .In_B      (in_b),
    .Out_Valid (out_valid),
    .Out_Ready (out_ready),
    .Out_Data  (out_data),
    .Busy      (busy)
  );

  logic        sw_iv   [4];
  logic        sw_ir   [4];
  logic        sw_ov   [4];
  logic        sw_busy [4];
  logic [31:0] sw_od   [4];
  logic [31:0] sw_a, sw_b;

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    gf256_mul_engine #(
      .LANES           (4),
      .STEPS_PER_CYCLE (1 << g),
      .POLY            (8'h1B)
    ) u_sw (
      .CLK       (clk),
      .RST       (rst),
      .In_Valid  (sw_iv[g]),
      .In_Ready  (sw_ir[g]),
      .In_A      (sw_a),
      .In_B      (sw_b),
      .Out_Valid (sw_ov[g]),
      .Out_Ready (1'b1),
      .Out_Data  (sw_od[g]),
      .Busy      (sw_busy[g])
    );
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          hs_count = 0;
  logic [31:0] exp_q [$];
  int          acc_q [$];
  logic [7:0]  exp_t [256];
  int          log_t [256];
  logic [7:0]  mul_tbl [65536];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Exhaustive product table built from log/antilog tables (generator 0x03).
  task automatic build_tables();
    int x;
    x = 1;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = 8'(x);
      log_t[x] = i;
      x = x ^ (x << 1);
      if ((x & 256) != 0) x = x ^ 32'h11B;
    end
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        mul_tbl[a*256+b] = (a == 0 || b == 0) ? 8'h00 : exp_t[(log_t[a] + log_t[b]) % 255];
      end
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = mul_tbl[{a[8*i +: 8], b[8*i +: 8]}];
    return r;
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv,
                      output int acc_edge);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      check(1'b0, "accept_timeout", 32'(in_ready), 32'd1);
      acc_edge = -1;
    end else begin
      exp_q.push_back(expv);
      acc_q.push_back(cyc + 1);
      acc_edge = cyc + 1;
    end
    @(posedge clk);
    #1;
    // Operands must be ignored once captured.
    in_a = ~a;
    in_b = ~b;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check(1'b0, "valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check(exp_q.size() == 0, "drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check(out_valid == 1'b0, "rst_out_valid", 32'(out_valid), 32'd0);
    check(out_data == 32'h0, "rst_out_data", out_data, 32'h0);
    check(in_ready == 1'b1, "rst_in_ready", 32'(in_ready), 32'd1);
    check(busy == 1'b0, "rst_busy", 32'(busy), 32'd0);
  endtask

  initial begin : monitor
    logic        ov_prev, hs_prev, hs;
    logic [31:0] e;
    int          a;
    ov_prev = 1'b0;
    hs_prev = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        ov_prev = 1'b0;
        hs_prev = 1'b0;
      end else begin
        if (!out_valid) check(out_data == 32'h0, "idle_data_zero", out_data, 32'h0);
        if (out_valid && (!ov_prev || hs_prev)) begin
          if (acc_q.size() == 0) check(1'b0, "valid_without_request", out_data, 32'h0);
          else begin
            a = acc_q.pop_front();
            check(cyc - a == Iter, "latency", 32'(cyc - a), 32'(Iter));
          end
        end
        hs = out_valid && out_ready;
        if (hs) begin
          hs_count++;
          if (exp_q.size() == 0) check(1'b0, "unexpected_result", out_data, 32'h0);
          else begin
            e = exp_q.pop_front();
            check(out_data == e, "result_data", out_data, e);
          end
        end
        ov_prev = out_valid;
        hs_prev = hs;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int          e, prev, hs_before, n;
    logic [31:0] ra, rb;
    build_tables();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    sw_a      = '0;
    sw_b      = '0;
    for (int g = 0; g < 4; g++) sw_iv[g] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check(out_valid == 1'b0, "reset_out_valid", 32'(out_valid), 32'd0);
    check(out_data == 32'h0, "reset_out_data", out_data, 32'h0);
    check(in_ready == 1'b1, "reset_in_ready", 32'(in_ready), 32'd1);
    check(busy == 1'b0, "reset_busy", 32'(busy), 32'd0);

    // Latency sweep over STEPS_PER_CYCLE 1/2/4/8 with the FIPS-197 vector.
    sw_a = 32'h57570B0B;
    sw_b = 32'h8313FF10;
    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      sw_iv[g] = 1'b1;
      #1;
      check(sw_ir[g] == 1'b1, "sweep_ready", 32'(sw_ir[g]), 32'd1);
      @(posedge clk);
      @(negedge clk);
      sw_iv[g] = 1'b0;
      check(sw_busy[g] == 1'b1, "sweep_busy", 32'(sw_busy[g]), 32'd1);
      n = 0;
      while (!sw_ov[g] && n < 20) begin
        @(negedge clk);
        n++;
      end
      check(n == (8 >> g), "sweep_latency", 32'(n), 32'(8 >> g));
      check(sw_od[g] == 32'hC1FEA3B0, "sweep_data", sw_od[g], 32'hC1FEA3B0);
      @(negedge clk);
    end

    // FIPS-197 vectors on the main instance.
    send(32'h57570B0B, 32'h8313FF10, 32'hC1FEA3B0, e);
    idle();
    drain();

    // Zero and identity operands.
    send(32'h00FF00FF, 32'hFF01FF01, 32'h00FF00FF, e);
    idle();
    drain();

    // Backpressure with a pending request held behind the stalled result.
    @(negedge clk);
    out_ready = 1'b0;
    send(32'h02038053, 32'h0E0B0201, 32'h1C1D1B53, e);
    idle();
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin
        in_valid = 1'b1;
        in_a     = 32'h0B0B0B0B;
        in_b     = 32'h01020408;
      end
      #1;
      check(out_valid == 1'b1, "bp_valid_held", 32'(out_valid), 32'd1);
      check(out_data == 32'h1C1D1B53, "bp_data_stable", out_data, 32'h1C1D1B53);
      check(in_ready == 1'b0, "bp_in_ready", 32'(in_ready), 32'd0);
      check(busy == 1'b1, "bp_busy", 32'(busy), 32'd1);
    end
    hs_before = hs_count;
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check(in_ready == 1'b1, "bp_release_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(32'h0B162C58);
    acc_q.push_back(cyc + 1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #3;
    check(hs_count == hs_before + 1, "bp_one_result", 32'(hs_count - hs_before), 32'd1);
    drain();

    // Back-to-back random traffic against the exhaustive table.
    prev = 0;
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      send(ra, rb, ref_word(ra, rb), e);
      if (i > 0) check(e - prev == Iter + 1, "b2b_interval", 32'(e - prev), 32'(Iter + 1));
      prev = e;
    end
    idle();
    drain();

    // Reset while BUSY, then while DONE; neither transaction may surface.
    send(32'h11223344, 32'h55667788, ref_word(32'h11223344, 32'h55667788), e);
    idle();
    pulse_reset();
    repeat (Iter + 2) @(negedge clk);
    #1;
    check(out_valid == 1'b0, "no_stale_busy", 32'(out_valid), 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
    send(32'hA5A5A5A5, 32'h5A5A5A5A, ref_word(32'hA5A5A5A5, 32'h5A5A5A5A), e);
    idle();
    wait_valid();
    pulse_reset();
    repeat (Iter + 2) @(negedge clk);
    #1;
    check(out_valid == 1'b0, "no_stale_done", 32'(out_valid), 32'd0);
    send(32'h01010101, 32'h0B0B0B0B, 32'h0B0B0B0B, e);
    idle();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
